vmem_wr_arb: RTL and testbench
==============================

VMEM_WR_ARB -- requirements
Module: vmem_wr_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, frame-buffer address width ({h_addr[9:0], v_addr[8:0]}).
REQ-002 The block SHALL have parameter DATA_W, default 24, pixel width (RGB888).
REQ-003 Port clk  input  1  pixel clock, same clock as VGA_CLK.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port blank  input  1  1 = VGA not in active display (inverse of VGA_BLANK_N).
REQ-006 Ports req0_valid, req1_valid  input  1 each  write request.
REQ-007 Ports req0_addr, req1_addr  input  ADDR_W each  write address.
REQ-008 Ports req0_data, req1_data  input  DATA_W each  write pixel.
REQ-009 Ports req0_ready, req1_ready  output  1 each  grant; a transfer occurs on a rising edge with valid=1 and ready=1.
REQ-010 Port fill_start  input  1  single-cycle pulse that starts a full-frame fill.
REQ-011 Port fill_color  input  DATA_W  fill pixel, sampled on the accepted fill_start edge.
REQ-012 Port fill_busy  output  1  fill in progress.
REQ-013 Port fill_done  output  1  one-cycle pulse when the fill completes.
REQ-014 Port mem_we  output  1  frame-buffer write strobe.
REQ-015 Ports mem_addr, mem_wdata  output  ADDR_W, DATA_W  write address and pixel.
REQ-016 Port wr_cnt  output  16  completed requester writes, saturating.

Function
REQ-017 readyN SHALL be combinational and equal to blank & reqN_valid & grantN & ~fill_busy; ready SHALL never depend on ready.
REQ-018 Exactly one requester SHALL be granted per cycle; a lone valid requester SHALL always be granted.
REQ-019 Contention SHALL be round-robin: the requester not granted last wins; the last-grant pointer SHALL update only on a completed transfer.
REQ-020 A transfer at edge N SHALL drive mem_we=1 with the transferred addr/data during cycle N+1; otherwise mem_we=0 and mem_addr/mem_wdata hold their values.
REQ-021 While blank=0 no write SHALL be issued, both readys=0, and requests SHALL stall without loss.
REQ-022 The fill FSM SHALL have states IDLE and FILL; IDLE->FILL on fill_start while in IDLE; fill_start in FILL SHALL be ignored.
REQ-023 In FILL, with an address counter starting at 0, each cycle with blank=1 SHALL issue one write (fill_color, counter) and increment the counter; cycles with blank=0 SHALL stall the counter.
REQ-024 After the write to address 2^ADDR_W-1 the FSM SHALL return to IDLE and assert fill_done for one cycle, coincident with that write's mem_we.
REQ-025 fill_busy SHALL be 1 exactly while in FILL; requesters SHALL receive no ready during FILL.
REQ-026 wr_cnt SHALL increment on each requester transfer (not fill writes) and saturate at 16'hFFFF.
REQ-027 A fill_start in the same cycle as a requester transfer SHALL let the transfer complete; FILL begins the next cycle.

Reset
REQ-028 While rst=1: mem_we=0, mem_addr=0, mem_wdata=0, fill_busy=0, fill_done=0, wr_cnt=0, FSM=IDLE, fill counter=0, last-grant pointer=req1 (so req0 wins the first contention).
REQ-029 Reset asserted during FILL SHALL abort the fill with no fill_done pulse.

Configuration
REQ-030 Macro VMEM_FILL_EN defined: fill FSM per REQ-022..025, REQ-027, REQ-029.
REQ-031 Macro VMEM_FILL_EN undefined: fill ports remain, fill_start and fill_color ignored, fill_busy=0 and fill_done=0 constant, no fill logic synthesized.

Verification
REQ-032 blank=1, req0_valid=1 addr=0x00010 data=0xFF0000, req1 idle -> req0_ready=1; next cycle mem_we=1, mem_addr=0x00010, mem_wdata=0xFF0000; wr_cnt=1.
REQ-033 Both valid, blank=1 for 4 cycles after reset -> grants req0, req1, req0, req1; wr_cnt=4.
REQ-034 req1_valid=1 with blank=0 for 10 cycles, then blank=1 -> no mem_we for 10 cycles; one write with the held addr/data on the cycle after blank rises.
REQ-035 ADDR_W=4, VMEM_FILL_EN, fill_start with fill_color=0x00FF00, blank toggling every 3 cycles -> 16 writes to addresses 0..15 in order, fill_done with the address-15 write, req0_valid held throughout gets ready only after fill_busy=0.
REQ-036 rst pulsed after 5 fill writes -> all outputs at reset values, no fill_done; a new fill_start restarts at address 0.
REQ-037 Without VMEM_FILL_EN, fill_start pulse -> fill_busy stays 0, no mem_we, requester grants unchanged.

Source files
------------

// File: rtl/vmem_wr_arb.sv
// Two-requester frame-buffer write arbiter, writes allowed only during blanking.
// Define VMEM_FILL_EN to build in the full-frame fill engine (IDLE/FILL FSM).
module vmem_wr_arb #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blank,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [15:0]       wr_cnt
);
    logic              last_q;   // 1 when req1 completed the most recent transfer
    logic              busy;
    logic              fill_wr;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_wdata;
    logic              grant0;
    logic              grant1;
    logic              xfer0;
    logic              xfer1;
    logic              mem_we_q;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [15:0]       wr_cnt_q;
    logic [15:0]       wr_cnt_d;
    logic              last_d;

    // valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // ready is derived from valid, the grant pointer, blank and fill state only.
    assign grant0     = ~req1_valid | last_q;
    assign grant1     = ~req0_valid | ~last_q;
    assign req0_ready = blank & req0_valid & grant0 & ~busy;
    assign req1_ready = blank & req1_valid & grant1 & ~busy;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;

`ifdef VMEM_FILL_EN
    typedef enum logic {S_IDLE, S_FILL} fill_state_e;

    fill_state_e       state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] color_q;
    logic              done_q;

    assign busy       = (state_q == S_FILL);
    assign fill_wr    = busy & blank;
    assign fill_addr  = cnt_q;
    assign fill_wdata = color_q;
    assign fill_busy  = busy;
    assign fill_done  = done_q;

    // done is registered alongside mem_we so it lands with the last fill write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fill_wr & (&cnt_q);
            case (state_q)
                S_IDLE: begin
                    if (fill_start) begin
                        state_q <= S_FILL;
                        cnt_q   <= '0;
                        color_q <= fill_color;
                    end
                end
                S_FILL: begin
                    if (blank) begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                        if (&cnt_q) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    logic fill_unused;

    assign busy        = 1'b0;
    assign fill_wr     = 1'b0;
    assign fill_addr   = '0;
    assign fill_wdata  = '0;
    assign fill_busy   = 1'b0;
    assign fill_done   = 1'b0;
    assign fill_unused = ^{fill_start, fill_color};
`endif

    always_comb begin
        mem_we_d    = xfer0 | xfer1 | fill_wr;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_cnt_d    = wr_cnt_q;
        last_d      = last_q;
        if (xfer0) begin
            mem_addr_d  = req0_addr;
            mem_wdata_d = req0_data;
        end else if (xfer1) begin
            mem_addr_d  = req1_addr;
            mem_wdata_d = req1_data;
        end else if (fill_wr) begin
            mem_addr_d  = fill_addr;
            mem_wdata_d = fill_wdata;
        end
        if (xfer0 | xfer1) begin
            last_d = xfer1;
            if (wr_cnt_q != 16'hFFFF) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_cnt_q    <= '0;
            last_q      <= 1'b1;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_cnt_q    <= wr_cnt_d;
            last_q      <= last_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_cnt    = wr_cnt_q;
endmodule

// File: tb/tb_vmem_wr_arb.sv
// Bench for vmem_wr_arb: directed vector table, corner sequences, random traffic vs model.
module tb_vmem_wr_arb;
`ifdef VMEM_FILL_EN
    localparam int AW = 4;
    localparam bit FILL_EN = 1'b1;
`else
    localparam int AW = 19;
    localparam bit FILL_EN = 1'b0;
`endif
    localparam int DW = 24;
    localparam logic [AW-1:0] DIR_ADDR = AW'(19'h00010);

    logic          clk = 1'b0;
    logic          rst;
    logic          blank;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          fill_start;
    logic [DW-1:0] fill_color;
    logic          fill_busy, fill_done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [15:0]   wr_cnt;

    vmem_wr_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .blank(blank),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int            m_last;
    bit            m_busy;
    int            m_cnt;
    logic [DW-1:0] m_color;
    int            m_wrcnt;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_done;
    bit            m_acc0, m_acc1;

    typedef struct {
        logic b, v0, v1, r0, r1;
        int   cnt;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_busy = 0; m_cnt = 0; m_color = '0; m_wrcnt = 0;
        m_we = 0; m_addr = '0; m_data = '0; m_done = 0; m_acc0 = 0; m_acc1 = 0;
    endtask

    task automatic idle_inputs();
        blank = 0; req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
        req0_data = '0; req1_data = '0; fill_start = 0; fill_color = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_fill_busy"}, fill_busy, 0);
        chk({tag, "_fill_done"}, fill_done, 0);
        chk({tag, "_wr_cnt"}, wr_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock: inputs are already driven; compare readys mid-cycle, outputs after the edge.
    task automatic cycle();
        logic er0, er1;
        bit   busy_pre;
        @(negedge clk);
        busy_pre = m_busy;
        er0 = blank && req0_valid && !m_busy && (!req1_valid || m_last == 1);
        er1 = blank && req1_valid && !m_busy && (!req0_valid || m_last == 0);
        chk("req0_ready", req0_ready, er0);
        chk("req1_ready", req1_ready, er1);
        m_acc0 = er0;
        m_acc1 = er1;
        m_done = 0;
        if (er0 || er1) begin
            m_we   = 1;
            m_addr = er0 ? req0_addr : req1_addr;
            m_data = er0 ? req0_data : req1_data;
            m_last = er0 ? 0 : 1;
            if (m_wrcnt < 65535) m_wrcnt++;
        end else if (m_busy && blank) begin
            m_we   = 1;
            m_addr = AW'(m_cnt);
            m_data = m_color;
            if (m_cnt == (1 << AW) - 1) begin
                m_done = 1;
                m_busy = 0;
            end
            m_cnt++;
        end else begin
            m_we = 0;
        end
        if (FILL_EN && !busy_pre && fill_start) begin
            m_busy  = 1;
            m_cnt   = 0;
            m_color = fill_color;
        end
        @(posedge clk);
        #1;
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
        chk("wr_cnt", wr_cnt, m_wrcnt);
        chk("fill_busy", fill_busy, m_busy);
        chk("fill_done", fill_done, m_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_seen;
        int nexp;
        int done_seen;
        logic [AW-1:0] done_addr;

        // blank, v0, v1, r0, r1, wr_cnt after the edge (pointer starts at req1)
        tbl[0]  = '{1, 1, 1, 1, 0, 1};
        tbl[1]  = '{1, 1, 1, 0, 1, 2};
        tbl[2]  = '{1, 1, 1, 1, 0, 3};
        tbl[3]  = '{1, 1, 1, 0, 1, 4};
        tbl[4]  = '{0, 1, 1, 0, 0, 4};
        tbl[5]  = '{1, 0, 1, 0, 1, 5};
        tbl[6]  = '{1, 0, 1, 0, 1, 6};
        tbl[7]  = '{1, 1, 1, 1, 0, 7};
        tbl[8]  = '{1, 0, 0, 0, 0, 7};
        tbl[9]  = '{1, 1, 0, 1, 0, 8};
        tbl[10] = '{1, 1, 1, 0, 1, 9};
        tbl[11] = '{0, 0, 1, 0, 0, 9};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            blank = tbl[i].b; req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
            req0_addr = AW'(i + 1); req0_data = 24'h100000 + DW'(i);
            req1_addr = AW'(i + 7); req1_data = 24'h200000 + DW'(i);
            @(negedge clk);
            chk($sformatf("tbl%0d_r0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_r1", i), req1_ready, tbl[i].r1);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].r0 | tbl[i].r1);
            chk($sformatf("tbl%0d_cnt", i), wr_cnt, tbl[i].cnt);
            if (tbl[i].r0) chk($sformatf("tbl%0d_addr", i), mem_addr, AW'(i + 1));
            if (tbl[i].r1) chk($sformatf("tbl%0d_data", i), mem_wdata, 24'h200000 + DW'(i));
        end

        // lone requester write
        do_reset();
        blank = 1; req0_valid = 1; req0_addr = DIR_ADDR; req0_data = 24'hFF0000;
        cycle();
        chk("lone_we", mem_we, 1);
        chk("lone_addr", mem_addr, DIR_ADDR);
        chk("lone_data", mem_wdata, 24'hFF0000);
        chk("lone_cnt", wr_cnt, 1);
        req0_valid = 0;

        // request held through active video, written once blanking returns
        do_reset();
        blank = 0; req1_valid = 1; req1_addr = AW'(5); req1_data = 24'h123456;
        we_seen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (mem_we) we_seen++;
        end
        chk("stall_no_we", we_seen, 0);
        blank = 1;
        cycle();
        chk("stall_we", mem_we, 1);
        chk("stall_addr", mem_addr, AW'(5));
        chk("stall_data", mem_wdata, 24'h123456);
        req1_valid = 0;

`ifdef VMEM_FILL_EN
        // fill with blank toggling; req0 transfers alongside fill_start then waits
        do_reset();
        blank = 1; req0_valid = 1; req0_addr = AW'(3); req0_data = 24'hABCDEF;
        fill_start = 1; fill_color = 24'h00FF00;
        cycle();
        fill_start = 0;
        chk("fill_start_xfer_cnt", wr_cnt, 1);
        nexp = 0; done_seen = 0; done_addr = '0;
        for (int k = 0; k < 200 && done_seen == 0; k++) begin
            blank = ((k / 3) % 2 == 0);
            cycle();
            if (mem_we) begin
                chk("fill_seq_addr", mem_addr, AW'(nexp));
                chk("fill_seq_data", mem_wdata, 24'h00FF00);
                nexp++;
            end
            if (fill_done) begin
                done_seen = 1;
                done_addr = mem_addr;
            end
        end
        chk("fill_writes", nexp, 16);
        chk("fill_done_seen", done_seen, 1);
        chk("fill_done_addr", done_addr, 15);
        blank = 1;
        cycle();
        chk("ready_after_fill_we", mem_we, 1);
        chk("ready_after_fill_addr", mem_addr, AW'(3));
        req0_valid = 0;

        // reset in the middle of a fill
        do_reset();
        blank = 1; fill_start = 1; fill_color = 24'h0000FF;
        cycle();
        fill_start = 0;
        nexp = 0;
        for (int k = 0; k < 50 && nexp < 5; k++) begin
            cycle();
            if (mem_we) nexp++;
        end
        chk("abort_writes", nexp, 5);
        @(negedge clk);
        rst = 1;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk);
        #1;
        chk("abort_no_done", fill_done, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        fill_start = 1; fill_color = 24'h0000FF;
        cycle();
        fill_start = 0;
        cycle();
        chk("restart_addr", mem_addr, 0);
        chk("restart_we", mem_we, 1);
`else
        // fill request ignored in this build
        do_reset();
        blank = 1; req0_valid = 1; req1_valid = 1; req0_addr = AW'(9); req1_addr = AW'(10);
        fill_start = 1; fill_color = 24'h00FF00;
        cycle();
        fill_start = 0;
        chk("nofill_busy", fill_busy, 0);
        chk("nofill_addr0", mem_addr, AW'(9));
        cycle();
        chk("nofill_addr1", mem_addr, AW'(10));
        req0_valid = 0; req1_valid = 0; blank = 0;
        cycle();
        chk("nofill_no_we", mem_we, 0);
`endif

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 800; k++) begin
            blank = ($urandom_range(0, 9) < 7);
            if (!req0_valid || m_acc0) begin
                req0_valid = $urandom_range(0, 1);
                req0_addr = AW'($urandom);
                req0_data = DW'($urandom);
            end
            if (!req1_valid || m_acc1) begin
                req1_valid = $urandom_range(0, 1);
                req1_addr = AW'($urandom);
                req1_data = DW'($urandom);
            end
            fill_start = ($urandom_range(0, 99) == 0);
            fill_color = DW'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
